// File: rtl/fea_pingpong_sched.sv
`default_nettype none
// ============================================================================
// Module   : fea_pingpong_sched
// Purpose  : Steers loader feature words into two ping-pong banks, throttles
//            the loader with halt, and hands full banks to the PE array.
// Options  : FEA_PINGPONG_STAT_EN adds halt_cnt / grant_cnt statistics.
// Revision : 1.0 - initial release
// ============================================================================
module fea_pingpong_sched #(
    parameter int WORD_W      = 400,
    parameter int BANK_DEPTH  = 75,
    parameter int ADDR_W      = 7,
    parameter int HALT_MARGIN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_v,
    input  logic [WORD_W-1:0] in_fea,
    output logic              halt,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    input  logic              pe_req,
    output logic              pe_grant,
    output logic              pe_bank,
    input  logic              pe_done,
    output logic [1:0]        bank_full,
`ifdef FEA_PINGPONG_STAT_EN
    output logic [15:0]       halt_cnt,
    output logic [15:0]       grant_cnt,
`endif
    output logic              overflow
);

    localparam int                FREE_W   = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] C_LAST   = ADDR_W'(BANK_DEPTH - 1);
    localparam logic [FREE_W-1:0] C_DEPTH  = FREE_W'(BANK_DEPTH);
    localparam logic [FREE_W-1:0] C_MARGIN = FREE_W'(HALT_MARGIN);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2,
        ST_READING = 2'd3
    } bank_st_t;

    bank_st_t          r_bank     [2];
    bank_st_t          w_bank_nxt [2];
    logic [ADDR_W-1:0] r_wptr, w_wptr_nxt;
    logic              r_ws, w_ws_nxt;
    logic              r_rs, w_rs_nxt;
    logic              w_any_rd, w_writable;
    logic              w_do_write, w_do_ovf, w_do_grant, w_do_rel;
    logic [FREE_W-1:0] w_left, w_free;

    function automatic logic is_held(input bank_st_t s);
        return (s == ST_FULL) || (s == ST_READING);
    endfunction

    always_comb begin
        w_bank_nxt = r_bank;
        w_wptr_nxt = r_wptr;
        w_ws_nxt   = r_ws;
        w_rs_nxt   = r_rs;
        w_any_rd   = (r_bank[0] == ST_READING) || (r_bank[1] == ST_READING);
        w_writable = (r_bank[r_ws] == ST_EMPTY) || (r_bank[r_ws] == ST_FILLING);
        w_do_write = in_v && w_writable;
        w_do_ovf   = in_v && !w_writable;
        // Only a bank already FULL before this edge is grantable: no bypass.
        w_do_grant = pe_req && !w_any_rd && (r_bank[r_rs] == ST_FULL);
        w_do_rel   = pe_done && w_any_rd;

        if (w_do_write) begin
            if (r_wptr == C_LAST) begin
                w_bank_nxt[r_ws] = ST_FULL;
                w_wptr_nxt       = '0;
                w_ws_nxt         = ~r_ws;
            end else begin
                w_bank_nxt[r_ws] = ST_FILLING;
                w_wptr_nxt       = r_wptr + 1'b1;
            end
        end
        if (w_do_grant) begin
            w_bank_nxt[r_rs] = ST_READING;
            w_rs_nxt         = ~r_rs;
        end
        // pe_bank always names the single READING bank.
        if (w_do_rel) begin
            w_bank_nxt[pe_bank] = ST_EMPTY;
        end

        w_left = '0;
        if ((w_bank_nxt[w_ws_nxt] == ST_EMPTY) || (w_bank_nxt[w_ws_nxt] == ST_FILLING)) begin
            w_left = C_DEPTH - {2'b00, w_wptr_nxt};
        end
        w_free = w_left + ((w_bank_nxt[~w_ws_nxt] == ST_EMPTY) ? C_DEPTH : '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bank[0] <= ST_EMPTY;
            r_bank[1] <= ST_EMPTY;
            r_wptr    <= '0;
            r_ws      <= 1'b0;
            r_rs      <= 1'b0;
            halt      <= 1'b1;
            wr_en     <= 1'b0;
            wr_bank   <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            pe_grant  <= 1'b0;
            pe_bank   <= 1'b0;
            bank_full <= 2'b00;
            overflow  <= 1'b0;
        end else begin
            r_bank    <= w_bank_nxt;
            r_wptr    <= w_wptr_nxt;
            r_ws      <= w_ws_nxt;
            r_rs      <= w_rs_nxt;
            halt      <= (w_free <= C_MARGIN);
            wr_en     <= w_do_write;
            if (w_do_write) begin
                wr_bank <= r_ws;
                wr_addr <= r_wptr;
                wr_data <= in_fea;
            end
            pe_grant  <= w_do_grant;
            if (w_do_grant) begin
                pe_bank <= r_rs;
            end
            bank_full <= {is_held(w_bank_nxt[1]), is_held(w_bank_nxt[0])};
            if (w_do_ovf) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef FEA_PINGPONG_STAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_cnt  <= '0;
            grant_cnt <= '0;
        end else begin
            if (halt && (halt_cnt != 16'hFFFF)) begin
                halt_cnt <= halt_cnt + 16'd1;
            end
            if (pe_grant && (grant_cnt != 16'hFFFF)) begin
                grant_cnt <= grant_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
